fetch_buffer: RTL

Decoupled instruction-fetch front end sitting between instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues in-order word requests to imem. Returned instructions are held in a DEPTH-entry in-order queue, so IF/ID stalls and memory latency do not throttle each other. Branch/jump redirects from EX flush the queue and silently discard responses already in flight.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, canonical NOP and the
// fetch queue entry payload.
package riscv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic            filled;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Decoupled instruction-fetch front end: owns the fetch PC, issues in-order
// imem requests and queues returned instructions for IF/ID, with redirect flush.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            req_valid,
   output logic [XLEN-1:0] req_addr,
   input  logic            req_ready,
   input  logic            resp_valid,
   input  logic [31:0]     resp_data,
   output logic            out_valid,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4,
   input  logic            out_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DW = $clog2(2 * DEPTH + 1);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [DEPTH-1:0] alloc_q, alloc_d;
   fetch_entry_t    entry_q [DEPTH];
   fetch_entry_t    entry_d [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   unfilled_q, unfilled_d;
   logic [DW-1:0]   discard_q, discard_d;

   logic         full;
   logic         issue;
   logic         pop;
   logic         drop;
   logic         fill;
   fetch_entry_t head;
   logic         unused_target_lsbs;

   assign unused_target_lsbs = ^redirect_target[1:0];

   assign full  = (count_q == CW'(DEPTH));
   assign head  = entry_q[rd_ptr_q];
   assign drop  = (discard_q != '0);
   assign fill  = resp_valid && !redirect_valid && !drop;

   assign req_valid    = reset && !full && !redirect_valid;
   assign req_addr     = reset ? fetch_pc_q : RESET_PC;
   assign out_valid    = reset && alloc_q[rd_ptr_q] && head.filled && !redirect_valid;
   assign out_instr    = head.instr;
   assign out_pc       = head.pc;
   assign out_pc_plus4 = head.pc + XLEN'(4);

   assign issue = req_valid && req_ready;
   assign pop   = out_valid && out_ready;

   // Next-state: redirect flushes everything and converts in-flight requests into discards
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      alloc_d    = alloc_q;
      entry_d    = entry_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fill_ptr_d = fill_ptr_q;
      count_d    = count_q;
      unfilled_d = unfilled_q;
      discard_d  = discard_q;

      if (redirect_valid) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            alloc_d[i]        = 1'b0;
            entry_d[i].filled = 1'b0;
         end
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fill_ptr_d = '0;
         count_d    = '0;
         unfilled_d = '0;
         fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
         discard_d  = discard_q + DW'(unfilled_q) - DW'(resp_valid);
      end else begin
         if (issue) begin
            alloc_d[wr_ptr_q]        = 1'b1;
            entry_d[wr_ptr_q].filled = 1'b0;
            entry_d[wr_ptr_q].pc     = fetch_pc_q;
            fetch_pc_d               = fetch_pc_q + XLEN'(4);
            wr_ptr_d                 = wr_ptr_q + PW'(1);
         end
         if (resp_valid && drop) begin
            discard_d = discard_q - DW'(1);
         end
         if (fill) begin
            entry_d[fill_ptr_q].instr  = resp_data;
            entry_d[fill_ptr_q].filled = 1'b1;
            fill_ptr_d                 = fill_ptr_q + PW'(1);
         end
         if (pop) begin
            alloc_d[rd_ptr_q]        = 1'b0;
            entry_d[rd_ptr_q].filled = 1'b0;
            rd_ptr_d                 = rd_ptr_q + PW'(1);
         end
         count_d    = count_q + CW'(issue) - CW'(pop);
         unfilled_d = unfilled_q + CW'(issue) - CW'(fill);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         alloc_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entry_q[i] <= '{filled: 1'b0, pc: '0, instr: INSTR_NOP};
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fill_ptr_q <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         alloc_q    <= alloc_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entry_q[i] <= entry_d[i];
         end
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         count_q    <= count_d;
         unfilled_q <= unfilled_d;
         discard_q  <= discard_d;
      end
   end

   // imem must never return more words than were requested
   resp_has_request: assert property (@(posedge clock) disable iff (!reset)
      resp_valid |-> (discard_q != '0 || unfilled_q != '0));

endmodule
